// File: rtl/rv32i_pc_rf_alu_if.sv
// Datapath bus between the control unit / memories and the RV32I PC + register file + ALU core.
// The master side (control) drives PC-next, register-file and ALU controls; the slave side is the core.
interface rv32i_pc_rf_alu_if;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic        we;
  logic [4:0]  addr1_r;
  logic [4:0]  addr2_r;
  logic [4:0]  addr3_w;
  logic [31:0] data_in;
  logic [31:0] imm;
  logic        alu_src;
  logic [3:0]  op;
  logic        u_s;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [31:0] alu_res;
  logic        zero;

  // No handshake: inputs are sampled on every rising clk edge, outputs are combinational/registered.
  modport master (
    output pc_next, we, addr1_r, addr2_r, addr3_w, data_in, imm, alu_src, op, u_s,
    input  pc, rd1, rd2, alu_res, zero
  );

  modport slave (
    input  pc_next, we, addr1_r, addr2_r, addr3_w, data_in, imm, alu_src, op, u_s,
    output pc, rd1, rd2, alu_res, zero
  );
endinterface

// File: rtl/rv32i_pc_rf_alu.sv
// Single-cycle RV32I datapath: PC register, 32x32 register file and ALU with operand-B mux.
// Optional macro RF_BYPASS_EN makes register reads write-first (same-edge write data forwarded).
module rv32i_pc_rf_alu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  rv32i_pc_rf_alu_if.slave bus
);

  logic [31:0] pc_q;
  logic [31:0] regs [32];
  logic [31:0] rd1_c;
  logic [31:0] rd2_c;
  logic [31:0] op_b;
  logic [4:0]  shamt;
  logic [31:0] alu_c;
  logic        wr_active;

  assign wr_active = bus.we && rst && (bus.addr3_w != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      // Bit 0 is always cleared so JALR targets land on an even address.
      pc_q <= bus.pc_next & 32'hFFFF_FFFE;
      if (wr_active) regs[bus.addr3_w] <= bus.data_in;
    end
  end

  function automatic logic [31:0] rf_read(input logic [4:0] addr);
    logic [31:0] v;
    v = (addr == 5'd0) ? 32'd0 : regs[addr];
`ifdef RF_BYPASS_EN
    if (wr_active && (bus.addr3_w == addr)) v = bus.data_in;
`else
    // Read-before-write: the stored value is returned even during a write to the same register.
`endif
    return v;
  endfunction

  always_comb begin
    rd1_c = rf_read(bus.addr1_r);
    rd2_c = rf_read(bus.addr2_r);
  end

  assign op_b  = bus.alu_src ? bus.imm : rd2_c;
  assign shamt = op_b[4:0];

  always_comb begin
    alu_c = 32'd0;
    case (bus.op)
      4'b0000: alu_c = rd1_c + op_b;
      4'b0001: alu_c = rd1_c - op_b;
      4'b0010: alu_c = rd1_c << shamt;
      4'b0011: alu_c = bus.u_s ? {31'd0, (rd1_c < op_b)}
                               : {31'd0, ($signed(rd1_c) < $signed(op_b))};
      4'b0100: alu_c = rd1_c ^ op_b;
      4'b0101: alu_c = rd1_c >> shamt;
      4'b0110: alu_c = $unsigned($signed(rd1_c) >>> shamt);
      4'b0111: alu_c = rd1_c | op_b;
      4'b1000: alu_c = rd1_c & op_b;
      4'b1001: alu_c = op_b;
      default: alu_c = 32'd0;
    endcase
  end

  assign bus.pc      = pc_q;
  assign bus.rd1     = rd1_c;
  assign bus.rd2     = rd2_c;
  assign bus.alu_res = alu_c;
  assign bus.zero    = ~|alu_c;

endmodule

// File: tb/tb_rv32i_pc_rf_alu.sv
// Self-checking bench for rv32i_pc_rf_alu: directed cases then randomized traffic against a reference model.
module tb_rv32i_pc_rf_alu;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  rv32i_pc_rf_alu_if bus ();

  rv32i_pc_rf_alu #(.RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [31:0] m_rf [32];
  logic [31:0] m_pc;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : m_rf[a];
`ifdef RF_BYPASS_EN
    if (bus.we && rst && bus.addr3_w != 5'd0 && bus.addr3_w == a) v = bus.data_in;
`endif
    return v;
  endfunction

  function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic u_s);
    logic [63:0] scale;
    logic [63:0] prod;
    scale = 64'd1 << b[4:0];
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: begin prod = {32'd0, a} * scale; return prod[31:0]; end
      4'd3: return u_s ? ((a < b) ? 32'd1 : 32'd0)
                       : (((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0);
      4'd4: return a ^ b;
      4'd5: return 32'({32'd0, a} / scale);
      4'd6: return a[31] ? ~(32'({32'd0, ~a} / scale)) : 32'({32'd0, a} / scale);
      4'd7: return a | b;
      4'd8: return a & b;
      4'd9: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // drive all bus inputs
  task automatic drive(input logic [31:0] pcn, input logic w, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] a3, input logic [31:0] din,
                       input logic [31:0] im, input logic src, input logic [3:0] op,
                       input logic us);
    bus.pc_next = pcn; bus.we = w; bus.addr1_r = a1; bus.addr2_r = a2; bus.addr3_w = a3;
    bus.data_in = din; bus.imm = im; bus.alu_src = src; bus.op = op; bus.u_s = us;
    #1;
  endtask

  // advance one edge, updating the model with the inputs in force at that edge
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      m_pc = RESET_PC;
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    end else begin
      m_pc = {bus.pc_next[31:1], 1'b0};
      if (bus.we && bus.addr3_w != 5'd0) m_rf[bus.addr3_w] = bus.data_in;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [31:0] a, b, r;
    a = m_read(bus.addr1_r);
    b = bus.alu_src ? bus.imm : m_read(bus.addr2_r);
    r = m_alu(bus.op, a, b, bus.u_s);
    check({tag, ".rd1"}, bus.rd1, a);
    check({tag, ".rd2"}, bus.rd2, m_read(bus.addr2_r));
    check({tag, ".alu"}, bus.alu_res, r);
    check({tag, ".zero"}, {31'd0, bus.zero}, {31'd0, r == 32'd0});
    check({tag, ".pc"}, bus.pc, m_pc);
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    drive(32'h0, 1'b1, 5'd0, 5'd0, a, d, 32'h0, 1'b0, 4'd0, 1'b0);
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    m_pc  = 32'hxxxx_xxxx;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'hxxxx_xxxx;

    // reset overrides a pending write to x5
    rst = 1'b0;
    drive($urandom, 1'b1, 5'd5, 5'd0, 5'd5, 32'hFFFF_FFFF, 32'h0, 1'b0, 4'd0, 1'b0);
    tick();
    check("reset.pc", bus.pc, RESET_PC);
    drive(32'h0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b0);
    check("reset.x5", bus.rd1, 32'h0);
    rst = 1'b1;

    // PC load with bit 0 forced low
    drive(32'h0000_0104, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b0);
    tick();
    check("pc.104", bus.pc, 32'h0000_0104);
    drive(32'h0000_0203, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b0);
    tick();
    check("pc.203", bus.pc, 32'h0000_0202);

    // register file write, same-edge read, x0 discard
    drive(32'h0, 1'b1, 5'd3, 5'd0, 5'd3, 32'hDEAD_BEEF, 32'h0, 1'b0, 4'd0, 1'b0);
`ifdef RF_BYPASS_EN
    check("rf.same_edge_x3", bus.rd1, 32'hDEAD_BEEF);
`else
    check("rf.same_edge_x3", bus.rd1, 32'h0);
`endif
    tick();
    drive(32'h0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0000_1234, 32'h0, 1'b0, 4'd0, 1'b0);
    check("rf.x0_same_edge", bus.rd1, 32'h0);
    tick();
    drive(32'h0, 1'b0, 5'd3, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b0);
    check("rf.x3", bus.rd1, 32'hDEAD_BEEF);
    check("rf.x0", bus.rd2, 32'h0);

    // signed vs unsigned compare, SUB
    write_reg(5'd1, 32'hFFFF_FFFF);
    write_reg(5'd2, 32'h0000_0001);
    drive(32'h0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 1'b0, 4'd3, 1'b0);
    check("slt.signed", bus.alu_res, 32'd1);
    drive(32'h0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 1'b0, 4'd3, 1'b1);
    check("slt.unsigned", bus.alu_res, 32'd0);
    drive(32'h0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 1'b0, 4'd1, 1'b0);
    check("sub.res", bus.alu_res, 32'hFFFF_FFFE);
    check("sub.zero", {31'd0, bus.zero}, 32'd0);

    // shifts with immediate operand, shamt taken from B[4:0]
    write_reg(5'd4, 32'h8000_0000);
    drive(32'h0, 1'b0, 5'd4, 5'd0, 5'd0, 32'h0, 32'h0000_0024, 1'b1, 4'd6, 1'b0);
    check("sra", bus.alu_res, 32'hF800_0000);
    drive(32'h0, 1'b0, 5'd4, 5'd0, 5'd0, 32'h0, 32'h0000_0024, 1'b1, 4'd5, 1'b0);
    check("srl", bus.alu_res, 32'h0800_0000);
    drive(32'h0, 1'b0, 5'd4, 5'd0, 5'd0, 32'h0, 32'h0000_0024, 1'b1, 4'd2, 1'b0);
    check("sll", bus.alu_res, 32'h0);

    // zero flag and PASSB, reserved opcodes
    write_reg(5'd7, 32'h0000_0007);
    drive(32'h0, 1'b0, 5'd7, 5'd7, 5'd0, 32'h0, 32'h0, 1'b0, 4'd1, 1'b0);
    check("zero.res", bus.alu_res, 32'h0);
    check("zero.flag", {31'd0, bus.zero}, 32'd1);
    drive(32'h0, 1'b0, 5'd7, 5'd7, 5'd0, 32'h0, 32'h1234_5000, 1'b1, 4'd9, 1'b0);
    check("passb", bus.alu_res, 32'h1234_5000);
    for (int k = 10; k < 16; k++) begin
      drive(32'h0, 1'b0, 5'd1, 5'd7, 5'd0, 32'h0, 32'h1234_5000, 1'b1, 4'(k), 1'b0);
      check("reserved_op", bus.alu_res, 32'h0);
    end

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) != 0);
      drive($urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom,
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      check_model("rand");
      tick();
      check("rand.pc_after", bus.pc, m_pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
